// File: rtl/main_memory_pkg.sv
// Package for the 1 KiB block-granular main memory.
// Holds the geometry parameters, derived widths, the word/block types and
// the helper that builds a block's power-on pattern.
package main_memory_pkg;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLK_WORDS = 4;

    localparam int unsigned BLK_W     = BLK_WORDS * WORD_W;            // 128
    localparam int unsigned NUM_BLK   = (2 ** ADDR_W) / (BLK_W / 8);   // 64
    localparam int unsigned BLK_IDX_W = $clog2(NUM_BLK);               // 6
    localparam int unsigned OFFS_W    = ADDR_W - BLK_IDX_W;            // 4

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BLK_W-1:0]  block_t;

    // Reset pattern: every word holds its own word index, so block b reads
    // {4b+3, 4b+2, 4b+1, 4b}.
    function automatic block_t reset_block(input int unsigned b);
        block_t blk;
        for (int unsigned k = 0; k < BLK_WORDS; k++) begin
            blk[k*WORD_W +: WORD_W] = word_t'(b * BLK_WORDS + k);
        end
        return blk;
    endfunction

endpackage

// File: rtl/main_memory_1k.sv
// main_memory_1k: 1 KiB backing memory behind the data cache.
// Every access moves one whole 16-byte block (4 x 32-bit words).
//
// Ports:
//   clk         system clock, state changes on rising edge
//   rst_n       asynchronous active-low reset; loads the word-index pattern
//   read_write  0 = read block, 1 = write block
//   address     byte address; block index = address[9:4], [3:0] ignored
//   writeData   block to store (word k in bits [32k+31:32k])
//   readData    block at address[9:4]
//
// Configuration:
//   MAIN_MEM_RDREG_EN  defined   -> readData registered (1-cycle latency,
//                                   resets to 0, shows pre-write contents)
//                      undefined -> combinational read (default)
module main_memory_1k
    import main_memory_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [BLK_W-1:0]  writeData,
    output logic [BLK_W-1:0]  readData
);

    logic [BLK_IDX_W-1:0] blk_idx;
    logic                 wr_en;
    block_t               rd_blk;
    block_t               mem_q [NUM_BLK];

    // Byte offset inside a block never selects or masks data.
    logic unused_offs;
    assign unused_offs = ^address[OFFS_W-1:0];

    assign blk_idx = address[ADDR_W-1:OFFS_W];

    always_comb begin
        wr_en  = read_write;
        rd_blk = mem_q[blk_idx];
    end

    // Reset wins over an in-flight write: the whole array reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NUM_BLK; b++) begin
                mem_q[b] <= reset_block(b);
            end
        end else if (wr_en) begin
            mem_q[blk_idx] <= writeData;
        end
    end

`ifdef MAIN_MEM_RDREG_EN
    block_t rdata_d;
    block_t rdata_q;

    // Samples the array before this edge's write lands.
    always_comb begin
        rdata_d = rd_blk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign readData = rdata_q;
`else
    // No write-through bypass: a same-block write shows up after the edge.
    assign readData = rd_blk;
`endif

endmodule

// File: tb/tb_main_memory_1k.sv
// Self-checking bench for main_memory_1k: directed stimulus, literal
// expectations, and a word-array reference model checked every cycle.
module tb_main_memory_1k;

    logic         clk;
    logic         clk_en;
    logic         rst_n;
    logic         read_write;
    logic [9:0]   address;
    logic [127:0] writeData;
    logic [127:0] readData;

    int n_cmp;
    int n_bad;
    bit started;

    main_memory_1k u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_write (read_write),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData)
    );

    always #5 clk = clk_en ? ~clk : clk;

    // Reference model: 256 plain words, word w = block w/4, lane w%4.
    logic [31:0]  mdl [256];
    logic [127:0] mdl_rd_q;

    function automatic logic [127:0] mdl_block(input int unsigned b);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = mdl[b*4 + k];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < 256; w++) mdl[w] <= 32'(w);
            mdl_rd_q <= '0;
        end else begin
            mdl_rd_q <= mdl_block(int'(address) / 16);
            if (read_write) begin
                for (int k = 0; k < 4; k++)
                    mdl[(int'(address) / 16) * 4 + k] <= writeData[32*k +: 32];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
`ifdef MAIN_MEM_RDREG_EN
            check("cycle_model", readData, mdl_rd_q);
`else
            check("cycle_model", readData, mdl_block(int'(address) / 16));
`endif
        end
    end

    task automatic read_chk(input string name, input logic [9:0] a,
                            input logic [127:0] exp);
        @(posedge clk);
        #2;
        read_write = 1'b0;
        address    = a;
`ifdef MAIN_MEM_RDREG_EN
        @(posedge clk);
        #2;
`endif
        #1;
        check(name, readData, exp);
    endtask

    localparam logic [127:0] Pat000  = 128'h00000003_00000002_00000001_00000000;
    localparam logic [127:0] Pat3f0  = 128'h000000FF_000000FE_000000FD_000000FC;
    localparam logic [127:0] Pat150  = 128'h00000057_00000056_00000055_00000054;
    localparam logic [127:0] Pat290  = 128'h000000A7_000000A6_000000A5_000000A4;
    localparam logic [127:0] Pat2a0  = 128'h000000AB_000000AA_000000A9_000000A8;
    localparam logic [127:0] Pat010  = 128'h00000007_00000006_00000005_00000004;
    localparam logic [127:0] WrVal   = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] NewVal  = 128'h11111111_22222222_33333333_44444444;

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        started    = 1'b0;
        clk        = 1'b0;
        clk_en     = 1'b0;
        rst_n      = 1'b1;
        read_write = 1'b0;
        address    = '0;
        writeData  = '0;

        // Reset pulse with the clock stopped.
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        address = 10'h000;
        #1;
`ifdef MAIN_MEM_RDREG_EN
        check("reset_rdreg_zero", readData, 128'h0);
`else
        check("reset_blk000", readData, Pat000);
        address = 10'h3F0;
        #1;
        check("reset_blk3f0", readData, Pat3f0);
`endif
        #2;
        started = 1'b1;
        clk_en  = 1'b1;

        read_chk("read_blk000", 10'h000, Pat000);
        read_chk("read_blk3f0", 10'h3F0, Pat3f0);
        read_chk("offs_150", 10'h150, Pat150);
        read_chk("offs_15c", 10'h15C, Pat150);

        // Write with a nonzero offset, read back at the block base.
        @(posedge clk);
        #2;
        read_write = 1'b1;
        address    = 10'h2A4;
        writeData  = WrVal;
        @(posedge clk);
        #2;
        read_write = 1'b0;
        read_chk("wr_readback_2a0", 10'h2A0, WrVal);
        read_chk("neighbour_290", 10'h290, Pat290);

        // Same-cycle read and write of one block: no bypass.
        @(posedge clk);
        #2;
        read_write = 1'b1;
        address    = 10'h010;
        writeData  = NewVal;
`ifndef MAIN_MEM_RDREG_EN
        #1;
        check("rdw_before_edge", readData, Pat010);
`endif
        @(posedge clk);
        #2;
        read_write = 1'b0;
        #1;
`ifdef MAIN_MEM_RDREG_EN
        check("rdw_reg_old", readData, Pat010);
        @(posedge clk);
        #3;
        check("rdw_reg_new", readData, NewVal);
`else
        check("rdw_after_edge", readData, NewVal);
`endif

        // Async reset between edges while a write is pending.
        @(posedge clk);
        #2;
        read_write = 1'b1;
        address    = 10'h2A0;
        writeData  = NewVal;
        #1 rst_n = 1'b0;
        #1;
`ifdef MAIN_MEM_RDREG_EN
        check("midwr_reset_now", readData, 128'h0);
`else
        check("midwr_reset_now", readData, Pat2a0);
`endif
        @(posedge clk);
        #3;
`ifdef MAIN_MEM_RDREG_EN
        check("midwr_reset_held", readData, 128'h0);
`else
        check("midwr_reset_held", readData, Pat2a0);
`endif
        read_write = 1'b0;
        #1 rst_n = 1'b1;
        read_chk("midwr_no_write", 10'h2A0, Pat2a0);
        read_chk("midwr_blk010_reset", 10'h010, Pat010);

        // Back-to-back writes of every block, then read them all.
        for (int b = 0; b < 64; b++) begin
            @(posedge clk);
            #2;
            read_write = 1'b1;
            address    = 10'(b * 16);
            writeData  = {4{32'(b)}};
        end
        @(posedge clk);
        #2;
        read_write = 1'b0;
        for (int b = 0; b < 64; b++) begin
            read_chk("b2b_readback", 10'(b * 16 + (b % 16)), {4{32'(b)}});
        end

        @(posedge clk);
        #3;
        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
